// File: rtl/arb_mux_nx1_pkg.sv
// -----------------------------------------------------------------------------
// mips_mux_pkg
//
// Purpose:
//   Shared definitions for the N:1 arbitrated multiplexer (arb_mux_nx1) and its
//   combinational arbiter (rr_arbiter).
//
// Contents:
//   mux_mode_e  - arbitration policy selector
//                 MUX_MODE_FIXED (0): lowest asserted index wins
//                 MUX_MODE_RR    (1): round-robin starting at a moving pointer
//   sel_width() - width of a channel index; never narrower than one bit so that
//                 a single-channel instance still has a legal select bus
// -----------------------------------------------------------------------------
package mips_mux_pkg;

  typedef enum logic {
    MUX_MODE_FIXED = 1'b0,
    MUX_MODE_RR    = 1'b1
  } mux_mode_e;

  // Index width for n channels. $clog2(1) is 0, which would give a zero-width
  // select, so a single channel is forced up to one bit.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_nx1_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Purpose:
//   Purely combinational one-hot arbiter. Picks exactly one asserted request,
//   or none when no request is asserted.
//
// Parameters:
//   N     - number of requesters
//   MODE  - MUX_MODE_FIXED: lowest asserted index wins (ptr is ignored)
//           MUX_MODE_RR   : first asserted index at or above ptr, wrapping
//                           from N-1 back to 0
//
// Ports:
//   req   [N-1:0]    in   request vector, bit i belongs to requester i
//   ptr   [SELW-1:0] in   round-robin start index (only meaningful in RR mode)
//   grant [N-1:0]    out  one-hot grant, all-zero when req is all-zero
// -----------------------------------------------------------------------------
module rr_arbiter
  import mips_mux_pkg::*;
#(
  parameter  int        N    = 4,
  parameter  mux_mode_e MODE = MUX_MODE_FIXED,
  localparam int        SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant
);

  // Fixed priority is just round-robin that always starts scanning at 0, so
  // both modes share one scan loop and differ only in the start index.
  logic [SELW-1:0] start;

  assign start = (MODE == MUX_MODE_RR) ? ptr : '0;

  // Scan all N positions beginning at the start index, wrapping modulo N.
  // The first asserted request seen takes the grant; 'found' blocks any later
  // hit so the result stays one-hot.
  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(start) + off) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux_nx1.sv
// -----------------------------------------------------------------------------
// arb_mux_nx1
//
// Purpose:
//   N-input to 1-output arbitrated multiplexer with valid/ready handshakes on
//   every channel and a single registered output stage. One beat per cycle
//   can flow through when downstream keeps out_ready high.
//
// Parameters:
//   WIDTH - data bits per channel (>= 1)
//   N     - number of input channels (>= 1)
//   MODE  - MUX_MODE_FIXED (lowest index wins) or MUX_MODE_RR (round-robin)
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous, active-low reset
//   in_valid   in   N          per-channel request
//   in_data    in   N*WIDTH    packed data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   out  N          per-channel accept (one-hot or zero)
//   out_valid  out  1          output register holds a beat
//   out_data   out  WIDTH      data of the held beat
//   out_sel    out  SELW       channel index that supplied the held beat
//   out_ready  in   1          downstream accept
// -----------------------------------------------------------------------------
module arb_mux_nx1
  import mips_mux_pkg::*;
#(
  parameter  int        WIDTH = 32,
  parameter  int        N     = 4,
  parameter  mux_mode_e MODE  = MUX_MODE_FIXED,
  localparam int        SELW  = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr;
  logic [N-1:0]     grant;
  logic             load;
  logic             xfer;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arbiter (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // The output register can take a new beat when it is empty or when its
  // current beat leaves this same cycle; the latter gives back-to-back
  // throughput with no bubble. in_ready is additionally forced low while
  // reset is held, because an empty register would otherwise look ready.
  assign load     = !out_valid || out_ready;
  assign in_ready = (rst_n && load) ? grant : '0;
  assign xfer     = |in_ready;

  // Turn the one-hot grant into an index and pick that channel's data. The
  // grant never depends on in_data, so the data path cannot feed back into
  // the handshake.
  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        grant_idx  = SELW'(i);
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage. An accepted input always overwrites the held beat (which
  // has either already left or is leaving now). With no new beat, a
  // downstream accept just empties the stage; data and index are left as
  // they were. With no accept, everything holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_sel   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer: after every accepted beat it moves to the channel
  // just past the winner, so the winner becomes lowest priority next time.
  // In fixed mode there is nothing to remember and the pointer is tied to 0.
  if (MODE == MUX_MODE_RR) begin : g_rr_ptr
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ptr <= '0;
      end else if (xfer) begin
        ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + SELW'(1);
      end
    end
  end else begin : g_fixed_ptr
    assign ptr = '0;
  end

endmodule

// File: tb/tb_arb_mux_nx1.sv
// -----------------------------------------------------------------------------
// tb_arb_mux_nx1
//
// Three instances of arb_mux_nx1 share one clock and reset:
//   u_fix : N=4, WIDTH=32, fixed priority
//   u_rr  : N=4, WIDTH=32, round-robin
//   u_one : N=1, WIDTH=8,  fixed priority
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked 1 unit later and registered outputs 1 unit after the next edge.
// -----------------------------------------------------------------------------
module tb_arb_mux_nx1;
  import mips_mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic [3:0]   f_in_valid, f_in_ready;
  logic [127:0] f_in_data;
  logic         f_out_valid, f_out_ready;
  logic [31:0]  f_out_data;
  logic [1:0]   f_out_sel;

  logic [3:0]   r_in_valid, r_in_ready;
  logic [127:0] r_in_data;
  logic         r_out_valid, r_out_ready;
  logic [31:0]  r_out_data;
  logic [1:0]   r_out_sel;

  logic         s_in_valid, s_in_ready;
  logic [7:0]   s_in_data;
  logic         s_out_valid, s_out_ready;
  logic [7:0]   s_out_data;
  logic         s_out_sel;

  arb_mux_nx1 #(.WIDTH(32), .N(4), .MODE(MUX_MODE_FIXED)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .in_valid(f_in_valid), .in_data(f_in_data), .in_ready(f_in_ready),
    .out_valid(f_out_valid), .out_data(f_out_data), .out_sel(f_out_sel),
    .out_ready(f_out_ready)
  );

  arb_mux_nx1 #(.WIDTH(32), .N(4), .MODE(MUX_MODE_RR)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .in_valid(r_in_valid), .in_data(r_in_data), .in_ready(r_in_ready),
    .out_valid(r_out_valid), .out_data(r_out_data), .out_sel(r_out_sel),
    .out_ready(r_out_ready)
  );

  arb_mux_nx1 #(.WIDTH(8), .N(1), .MODE(MUX_MODE_FIXED)) u_one (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_sel(s_out_sel),
    .out_ready(s_out_ready)
  );

  typedef struct {
    logic [3:0]   valid;
    logic [127:0] data;
    logic         oready;
    logic [3:0]   exp_ready;
    logic         exp_ov;
    logic [31:0]  exp_od;
    logic [1:0]   exp_os;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [127:0] pack4(input logic [31:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one table row into the fixed-priority instance, check the
  // combinational accept, then the registered result after the next edge.
  task automatic applyStimulus(input vec_t v, input int k);
    f_in_valid  = v.valid;
    f_in_data   = v.data;
    f_out_ready = v.oready;
    #1;
    checkOutput($sformatf("fix%0d_in_ready", k), 64'(f_in_ready), 64'(v.exp_ready));
    tick();
    checkOutput($sformatf("fix%0d_out_valid", k), 64'(f_out_valid), 64'(v.exp_ov));
    checkOutput($sformatf("fix%0d_out_data", k), 64'(f_out_data), 64'(v.exp_od));
    checkOutput($sformatf("fix%0d_out_sel", k), 64'(f_out_sel), 64'(v.exp_os));
  endtask

  vec_t vecs[10];

  initial begin
    logic [127:0] d_a, d_b, d_rr;
    int sent, recvd;
    logic smp_ir, smp_ov;
    logic [7:0] smp_od;
    logic [3:0] exp_gnt;

    d_a  = pack4(32'hA0, 32'h11, 32'h22, 32'h33);
    d_b  = pack4(32'hA1, 32'h12, 32'h22, 32'h33);
    d_rr = pack4(32'hC0, 32'hC1, 32'hC2, 32'hC3);

    // valid, data, out_ready, exp in_ready, exp out_valid, exp out_data, exp out_sel
    vecs[0] = '{4'b1010, d_a, 1'b1, 4'b0010, 1'b1, 32'h11, 2'd1};
    vecs[1] = '{4'b1010, d_b, 1'b1, 4'b0010, 1'b1, 32'h12, 2'd1};
    vecs[2] = '{4'b1000, d_b, 1'b1, 4'b1000, 1'b1, 32'h33, 2'd3};
    vecs[3] = '{4'b1000, d_b, 1'b0, 4'b0000, 1'b1, 32'h33, 2'd3};
    vecs[4] = '{4'b0000, d_b, 1'b1, 4'b0000, 1'b0, 32'h33, 2'd3};
    vecs[5] = '{4'b0000, d_a, 1'b0, 4'b0000, 1'b0, 32'h33, 2'd3};
    vecs[6] = '{4'b1111, d_a, 1'b0, 4'b0001, 1'b1, 32'hA0, 2'd0};
    vecs[7] = '{4'b0110, d_a, 1'b0, 4'b0000, 1'b1, 32'hA0, 2'd0};
    vecs[8] = '{4'b0110, d_a, 1'b1, 4'b0010, 1'b1, 32'h11, 2'd1};
    vecs[9] = '{4'b0100, d_b, 1'b1, 4'b0100, 1'b1, 32'h22, 2'd2};

    f_in_valid = 4'b1111; f_in_data = d_a; f_out_ready = 1'b0;
    r_in_valid = 4'b1111; r_in_data = d_rr; r_out_ready = 1'b0;
    s_in_valid = 1'b1; s_in_data = 8'h5A; s_out_ready = 1'b0;

    // Reset state, with requests present to show in_ready stays low.
    #1;
    checkOutput("rst_fix_out_valid", 64'(f_out_valid), 64'd0);
    checkOutput("rst_fix_out_data", 64'(f_out_data), 64'd0);
    checkOutput("rst_fix_out_sel", 64'(f_out_sel), 64'd0);
    checkOutput("rst_fix_in_ready", 64'(f_in_ready), 64'd0);
    checkOutput("rst_rr_in_ready", 64'(r_in_ready), 64'd0);
    checkOutput("rst_one_in_ready", 64'(s_in_ready), 64'd0);
    tick();
    tick();
    checkOutput("rst_fix_held_after_edge", 64'(f_out_valid), 64'd0);
    rst_n = 1'b1;
    r_in_valid = 4'b0000;
    s_in_valid = 1'b0;

    // Fixed-priority table.
    for (int k = 0; k < 10; k++) applyStimulus(vecs[k], k);

    // Back-pressure: load 0xDEADBEEF, stall 5 cycles with ch0 pending, then
    // release and expect ch0 to load at that same edge.
    f_in_valid = 4'b0100; f_in_data = pack4(32'h0, 32'h0, 32'hDEADBEEF, 32'h0); f_out_ready = 1'b1;
    tick();
    checkOutput("bp_load_data", 64'(f_out_data), 64'hDEADBEEF);
    f_in_valid = 4'b0001; f_in_data = pack4(32'h5555AAAA, 32'h0, 32'hDEADBEEF, 32'h0); f_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput($sformatf("bp%0d_in_ready", c), 64'(f_in_ready), 64'd0);
      tick();
      checkOutput($sformatf("bp%0d_out_valid", c), 64'(f_out_valid), 64'd1);
      checkOutput($sformatf("bp%0d_out_data", c), 64'(f_out_data), 64'hDEADBEEF);
      checkOutput($sformatf("bp%0d_out_sel", c), 64'(f_out_sel), 64'd2);
    end
    f_out_ready = 1'b1;
    #1;
    checkOutput("bp_release_in_ready", 64'(f_in_ready), 64'b0001);
    tick();
    checkOutput("bp_release_out_valid", 64'(f_out_valid), 64'd1);
    checkOutput("bp_release_out_data", 64'(f_out_data), 64'h5555AAAA);
    checkOutput("bp_release_out_sel", 64'(f_out_sel), 64'd0);
    f_in_valid = 4'b0000; f_out_ready = 1'b0;

    // Round-robin fairness: all channels valid, downstream always ready.
    r_in_valid = 4'b1111; r_in_data = d_rr; r_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      #1;
      checkOutput($sformatf("rr%0d_in_ready", k), 64'(r_in_ready), 64'(exp_gnt));
      tick();
      checkOutput($sformatf("rr%0d_out_sel", k), 64'(r_out_sel), 64'(k % 4));
      checkOutput($sformatf("rr%0d_out_valid", k), 64'(r_out_valid), 64'd1);
      checkOutput($sformatf("rr%0d_out_data", k), 64'(r_out_data), 64'(32'hC0 + (k % 4)));
    end

    // Sparse requests around the wrap: ch2 moves ptr to 3, ch0 alone wins
    // from ptr=3 (ptr -> 1), then {ch2, ch0} must go to ch2.
    r_in_valid = 4'b0100;
    #1; checkOutput("rrw_a_in_ready", 64'(r_in_ready), 64'b0100);
    tick(); checkOutput("rrw_a_out_sel", 64'(r_out_sel), 64'd2);
    r_in_valid = 4'b0001;
    #1; checkOutput("rrw_b_in_ready", 64'(r_in_ready), 64'b0001);
    tick(); checkOutput("rrw_b_out_sel", 64'(r_out_sel), 64'd0);
    r_in_valid = 4'b0101;
    #1; checkOutput("rrw_c_in_ready", 64'(r_in_ready), 64'b0100);
    tick(); checkOutput("rrw_c_out_sel", 64'(r_out_sel), 64'd2);
    checkOutput("rrw_c_out_data", 64'(r_out_data), 64'hC2);
    r_in_valid = 4'b0000; r_out_ready = 1'b0;

    // Mid-beat asynchronous reset: both instances hold a beat (ptr of u_rr is
    // now 3). Reset must clear outputs between clock edges.
    f_in_valid = 4'b1111; f_in_data = d_a; f_out_ready = 1'b0;
    #1;
    checkOutput("pre_rst_fix_valid", 64'(f_out_valid), 64'd1);
    checkOutput("pre_rst_rr_valid", 64'(r_out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_fix_out_valid", 64'(f_out_valid), 64'd0);
    checkOutput("mid_rst_fix_out_data", 64'(f_out_data), 64'd0);
    checkOutput("mid_rst_fix_out_sel", 64'(f_out_sel), 64'd0);
    checkOutput("mid_rst_fix_in_ready", 64'(f_in_ready), 64'd0);
    checkOutput("mid_rst_rr_out_valid", 64'(r_out_valid), 64'd0);
    checkOutput("mid_rst_rr_out_data", 64'(r_out_data), 64'd0);
    tick();
    rst_n = 1'b1;
    f_in_valid = 4'b0000;
    r_in_valid = 4'b1010; r_out_ready = 1'b1;
    #1;
    checkOutput("post_rst_rr_in_ready", 64'(r_in_ready), 64'b0010);
    tick();
    checkOutput("post_rst_rr_out_sel", 64'(r_out_sel), 64'd1);
    checkOutput("post_rst_rr_out_data", 64'(r_out_data), 64'hC1);
    r_in_valid = 4'b0000;

    // N=1 stream 0x00..0xFF with random downstream stalls; every value must
    // come out once, in order, with out_sel held at 0.
    sent = 0;
    recvd = 0;
    for (int cyc = 0; cyc < 3000 && recvd < 256; cyc++) begin
      s_in_valid  = (sent < 256);
      s_in_data   = 8'(sent);
      s_out_ready = 1'($urandom_range(0, 1));
      #1;
      smp_ir = s_in_ready;
      smp_ov = s_out_valid;
      smp_od = s_out_data;
      checkOutput("one_in_ready", 64'(smp_ir), 64'(s_in_valid && (!smp_ov || s_out_ready)));
      if (smp_ov) checkOutput("one_out_sel", 64'(s_out_sel), 64'd0);
      if (smp_ov && s_out_ready) begin
        checkOutput($sformatf("one_data_%0d", recvd), 64'(smp_od), 64'(recvd));
        recvd++;
      end
      if (s_in_valid && smp_ir) sent++;
      tick();
    end
    checkOutput("one_received_count", 64'(recvd), 64'd256);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
